// File: rtl/dmem_arbiter.sv
// Two-port load/store front end for a 1024 x 32-bit word memory. Requests from
// p0/p1 are arbitrated round-robin and turned into word accesses (RMW for SB/SH).
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [1:0]  p0_req_size,
  input  logic        p0_req_unsigned,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_resp_valid,
  input  logic        p0_resp_ready,
  output logic [31:0] p0_resp_rdata,
  output logic        p0_resp_err,

  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [1:0]  p1_req_size,
  input  logic        p1_req_unsigned,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_resp_valid,
  input  logic        p1_resp_ready,
  output logic [31:0] p1_resp_rdata,
  output logic        p1_resp_err,

  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACC  = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_ERR  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  state_q, state_d;
  logic        last_q, last_d;     // port granted on the most recent acceptance
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  // Holds the extended load result, or the old word during a sub-word store.
  logic [31:0] data_q, data_d;

  logic        grant;
  logic        accept;
  logic        sel_we, sel_uns, owner_resp_ready;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged;

  function automatic logic access_invalid(input logic [1:0] size, input logic [31:0] addr);
    logic [32:0] end_addr;
    logic        bad;
    bad      = 1'b0;
    end_addr = {1'b0, addr};
    case (size)
      SZ_BYTE: end_addr = {1'b0, addr} + 33'd1;
      SZ_HALF: begin
        bad      = addr[0];
        end_addr = {1'b0, addr} + 33'd2;
      end
      SZ_WORD: begin
        bad      = |addr[1:0];
        end_addr = {1'b0, addr} + 33'd4;
      end
      default: bad = 1'b1;
    endcase
    if (end_addr > 33'(MEM_BYTES)) bad = 1'b1;
    return bad;
  endfunction

  // Round-robin only breaks ties; a lone requester always wins.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    grant = 1'b0;
    if (p0_req_valid && p1_req_valid) grant = ~last_q;
    else if (p1_req_valid)            grant = 1'b1;
  end

  assign sel_we    = grant ? p1_req_we       : p0_req_we;
  assign sel_size  = grant ? p1_req_size     : p0_req_size;
  assign sel_uns   = grant ? p1_req_unsigned : p0_req_unsigned;
  assign sel_addr  = grant ? p1_req_addr     : p0_req_addr;
  assign sel_wdata = grant ? p1_req_wdata    : p0_req_wdata;
  assign accept    = (state_q == ST_IDLE) && (grant ? p1_req_valid : p0_req_valid);
  assign owner_resp_ready = owner_q ? p1_resp_ready : p0_resp_ready;

  assign byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_BYTE: load_ext = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_ext = {{16{~uns_q & half_lane[15]}}, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = data_q;
    if (size_q == SZ_BYTE) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant;
          last_d  = grant;
          we_d    = sel_we;
          size_d  = sel_size;
          uns_d   = sel_uns;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = access_invalid(sel_size, sel_addr) ? ST_ERR : ST_ACC;
        end
      end
      ST_ACC: begin
        if (!we_q) begin
          data_d  = load_ext;
          state_d = ST_RESP;
        end else if (size_q == SZ_WORD) begin
          state_d = ST_RESP;
        end else begin
          data_d  = mem_rdata;
          state_d = ST_WR;
        end
      end
      ST_WR: state_d = ST_RESP;
      ST_ERR, ST_RESP: if (owner_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // Reset forces IDLE asynchronously, which zeroes every state-derived output.
  assign mem_we    = (state_q == ST_WR) || (state_q == ST_ACC && we_q && size_q == SZ_WORD);
  assign mem_addr  = (state_q == ST_ACC || state_q == ST_WR) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata = !mem_we ? '0 : ((state_q == ST_WR) ? merged : wdata_q);
  assign busy      = (state_q != ST_IDLE);

  assign p0_req_ready  = rst_n && (state_q == ST_IDLE) && !grant;
  assign p1_req_ready  = rst_n && (state_q == ST_IDLE) && grant;
  assign p0_resp_valid = (state_q == ST_RESP || state_q == ST_ERR) && !owner_q;
  assign p1_resp_valid = (state_q == ST_RESP || state_q == ST_ERR) && owner_q;
  assign p0_resp_err   = (state_q == ST_ERR) && !owner_q;
  assign p1_resp_err   = (state_q == ST_ERR) && owner_q;
  assign p0_resp_rdata = (state_q == ST_RESP && !owner_q && !we_q) ? data_q : '0;
  assign p1_resp_rdata = (state_q == ST_RESP && owner_q && !we_q) ? data_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected responses, a monitor
// pops and compares them on every response handshake.
module tb_dmem_arbiter;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, req_uns, resp_valid, resp_ready, resp_err;
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata[2];
  logic        mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [1024];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0, failures = 0, cyc = 0, we_count = 0, last_we_cyc = -1;
  int   p1_acc;
  bit   p1_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr[11:2]];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(req_valid[0]), .p0_req_ready(req_ready[0]), .p0_req_we(req_we[0]),
    .p0_req_size(req_size[0]), .p0_req_unsigned(req_uns[0]), .p0_req_addr(req_addr[0]),
    .p0_req_wdata(req_wdata[0]), .p0_resp_valid(resp_valid[0]), .p0_resp_ready(resp_ready[0]),
    .p0_resp_rdata(resp_rdata[0]), .p0_resp_err(resp_err[0]),
    .p1_req_valid(req_valid[1]), .p1_req_ready(req_ready[1]), .p1_req_we(req_we[1]),
    .p1_req_size(req_size[1]), .p1_req_unsigned(req_uns[1]), .p1_req_addr(req_addr[1]),
    .p1_req_wdata(req_wdata[1]), .p1_resp_valid(resp_valid[1]), .p1_resp_ready(resp_ready[1]),
    .p1_resp_rdata(resp_rdata[1]), .p1_resp_err(resp_err[1]),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a request, wait for acceptance, record the expected response.
  task automatic do_req(input int p, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                        output int acc);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    acc = -1;
    req_we[p] = we; req_size[p] = size; req_uns[p] = uns;
    req_addr[p] = addr; req_wdata[p] = wdata; req_valid[p] = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[p]) ok = 1'b1;
    end
    if (!ok) begin
      check($sformatf("p%0d_accept_timeout", p), 32'd0, 32'd1);
      req_valid[p] = 1'b0;
      return;
    end
    acc = cyc;
    e = '{rdata: exp_rdata, err: exp_err, lat: lat, acc: acc};
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
    req_addr[p]  = $urandom;
    req_wdata[p] = $urandom;
    req_we[p]    = 1'($urandom);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && resp_valid == 2'b00) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  {30'd0, req_ready}, 32'd0);
    check({tag, "_resp_valid"}, {30'd0, resp_valid}, 32'd0);
    check({tag, "_mem_we"},     {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"},   mem_addr, 32'd0);
    check({tag, "_mem_wdata"},  mem_wdata, 32'd0);
    check({tag, "_busy"},       {31'd0, busy}, 32'd0);
    check({tag, "_rdata0"},     resp_rdata[0] | resp_rdata[1], 32'd0);
    check({tag, "_err"},        {30'd0, resp_err}, 32'd0);
  endtask

  task automatic stimulus();
    int a0, a1, a2, acc, wc, hs;
    bit ok;
    rst_n = 1'b0;
    resp_ready = 2'b11;
    req_valid = 2'b00; req_we = 2'b00; req_uns = 2'b00;
    for (int p = 0; p < 2; p++) begin
      req_size[p] = W; req_addr[p] = '0; req_wdata[p] = '0;
    end
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[5] = 32'h1234_5678;
    mem[1023] = 32'hCAFE_F00D;

    // Both ports request through reset; first tie to p0, p0 re-requests so second tie goes to p1.
    fork
      begin
        do_req(0, 1'b0, W, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0, 2, a0);
        do_req(0, 1'b0, H, 1'b1, 32'h6, 32'h0, 32'h0000_2222, 1'b0, 2, a2);
      end
      do_req(1, 1'b0, W, 1'b0, 32'h4, 32'h0, 32'h2222_2222, 1'b0, 2, a1);
      begin
        repeat (3) begin
          @(negedge clk);
          check_all_zero("rst");
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("tie1_ready", {30'd0, req_ready}, 32'd1);
      end
    join
    wait_drain();
    check("tie2_p1_accept_cycle", a1, a0 + 3);
    check("p0_after_p1_accept_cycle", a2, a1 + 3);

    // Word store then sub-word loads.
    do_req(0, 1'b1, W, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, acc);
    do_req(0, 1'b0, B, 1'b1, 32'h11, 32'h0, 32'h0000_00BE, 1'b0, 2, acc);
    do_req(0, 1'b0, B, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 2, acc);
    wait_drain();
    check("sw_mem_word", mem[4], 32'hDEAD_BEEF);

    // Byte read-modify-write.
    wc = we_count;
    do_req(0, 1'b1, B, 1'b0, 32'h12, 32'h0000_0055, 32'h0, 1'b0, 3, acc);
    wait_drain();
    check("sb_we_pulses", we_count - wc, 32'd1);
    check("sb_write_cycle", last_we_cyc, acc + 2);
    check("sb_mem_word", mem[4], 32'hDE55_BEEF);
    do_req(0, 1'b0, H, 1'b0, 32'h12, 32'h0, 32'hFFFF_DE55, 1'b0, 2, acc);
    // Halfword RMW in the upper lane from p1.
    do_req(1, 1'b1, H, 1'b0, 32'h1A, 32'h1234_A5A5, 32'h0, 1'b0, 3, acc);
    do_req(1, 1'b0, W, 1'b0, 32'h18, 32'h0, 32'hA5A5_0000, 1'b0, 2, acc);
    wait_drain();

    // Invalid accesses never touch memory.
    wc = we_count;
    do_req(0, 1'b0, W, 1'b0, 32'h6,    32'h0,    32'h0, 1'b1, 1, acc);
    do_req(0, 1'b1, H, 1'b0, 32'h3,    32'hFFFF, 32'h0, 1'b1, 1, acc);
    do_req(1, 1'b0, X, 1'b0, 32'h0,    32'h0,    32'h0, 1'b1, 1, acc);
    do_req(0, 1'b0, W, 1'b0, 32'h1000, 32'h0,    32'h0, 1'b1, 1, acc);
    do_req(1, 1'b1, B, 1'b0, 32'h1000, 32'h77,   32'h0, 1'b1, 1, acc);
    do_req(1, 1'b0, H, 1'b0, 32'hFFF,  32'h0,    32'h0, 1'b1, 1, acc);
    wait_drain();
    check("err_no_mem_we", we_count - wc, 32'd0);

    // Last valid addresses.
    do_req(0, 1'b0, W, 1'b0, 32'hFFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2, acc);
    do_req(0, 1'b0, B, 1'b0, 32'hFFF, 32'h0, 32'hFFFF_FFCA, 1'b0, 2, acc);
    do_req(1, 1'b0, H, 1'b1, 32'hFFE, 32'h0, 32'h0000_CAFE, 1'b0, 2, acc);
    wait_drain();

    // Response back-pressure with the other port waiting.
    resp_ready[0] = 1'b0;
    do_req(0, 1'b0, W, 1'b0, 32'h10, 32'h0, 32'hDE55_BEEF, 1'b0, 2, acc);
    p1_done = 1'b0;
    fork
      begin
        do_req(1, 1'b0, W, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0, 2, p1_acc);
        p1_done = 1'b1;
      end
    join_none
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (resp_valid[0]) ok = 1'b1;
    end
    check("stall_valid_seen", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", {31'd0, resp_valid[0]}, 32'd1);
      check("stall_rdata", resp_rdata[0], 32'hDE55_BEEF);
      check("stall_p1_ready", {31'd0, req_ready[1]}, 32'd0);
    end
    @(posedge clk);
    #1 resp_ready[0] = 1'b1;
    @(negedge clk);
    hs = cyc;
    for (int i = 0; i < 50 && !p1_done; i++) @(negedge clk);
    check("stall_p1_done", {31'd0, p1_done}, 32'd1);
    wait_drain();
    check("stall_p1_accept_cycle", p1_acc, hs + 1);

    // Reset during the write cycle of a byte store.
    do_req(0, 1'b1, B, 1'b0, 32'h14, 32'h0000_00AA, 32'h0, 1'b0, 3, acc);
    @(posedge clk);
    #1;
    check("wr_mem_we_before_rst", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    check("rst_wr_mem_unchanged", mem[5], 32'h1234_5678);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(0, 1'b0, W, 1'b0, 32'h14, 32'h0, 32'h1234_5678, 1'b0, 2, acc);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      end
      begin : monitor
        int first [2];
        bit seen  [2];
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        forever begin
          @(negedge clk);
          if (mem_we) begin
            we_count++;
            last_we_cyc = cyc;
          end
          if (!rst_n) begin
            seen[0] = 1'b0;
            seen[1] = 1'b0;
          end
          for (int p = 0; p < 2; p++) begin
            if (resp_valid[p]) begin
              exp_t e;
              bit   have;
              if (!seen[p]) begin
                seen[p]  = 1'b1;
                first[p] = cyc;
              end
              if (resp_ready[p]) begin
                have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (!have) begin
                  check($sformatf("p%0d_unexpected_resp", p), 32'd1, 32'd0);
                end else begin
                  e = (p == 0) ? q0.pop_front() : q1.pop_front();
                  check($sformatf("p%0d_rdata", p), resp_rdata[p], e.rdata);
                  check($sformatf("p%0d_err", p), {31'd0, resp_err[p]}, {31'd0, e.err});
                  check($sformatf("p%0d_latency", p), first[p] - e.acc, e.lat);
                end
                seen[p] = 1'b0;
              end
            end
          end
        end
      end
      stimulus();
    join
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port load/store controller in front of the word-organised data memory (1024 x 32-bit, asynchronous read, synchronous word write, no byte strobes). It arbitrates between the core load/store port (p0) and a secondary master (p1, debug/DMA). It converts byte, halfword and word accesses into word reads and writes, using a two-cycle read-modify-write for sub-word stores. It also performs sign or zero extension and alignment/range checking, and returns a response on a valid/ready channel.

## Interface
- MEM_BYTES, 4096, addressable bytes; addresses >= MEM_BYTES are out of range
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- pN_req_valid  in  1  request present (N = 0, 1; all pN signals are duplicated per port)
- pN_req_ready  out  1  request accepted this cycle
- pN_req_we  in  1  1 = store, 0 = load
- pN_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- pN_req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- pN_req_addr  in  32  byte address
- pN_req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- pN_resp_valid  out  1  response present
- pN_resp_ready  in  1  response consumed
- pN_resp_rdata  out  32  extended load data; 0 for stores and errors
- pN_resp_err  out  1  misaligned, illegal size or out-of-range access
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory byte address, word-aligned ([1:0] = 0)
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr
- busy  out  1  state != IDLE

## Operation
- FSM states and transitions:
  - IDLE: accept a request from the granted port. Go to ERR if the access is invalid, otherwise to ACC.
  - ACC: load, SW or valid SB/SH access in progress.
    - Load: capture the mem_rdata lane, extend it, go to RESP.
    - SW: mem_we = 1 with wdata, go to RESP.
    - SB/SH: capture mem_rdata into the merge register, go to WR.
  - WR: mem_we = 1, mem_wdata = merge register with the new byte/half inserted in lane addr[1:0]. Go to RESP.
  - ERR: no memory access; resp_err = 1, rdata = 0. Behaves as RESP.
  - RESP: resp_valid is high on the owning port only. Go to IDLE on resp_ready.
- Invalid access: any of the following.
  - size = 11.
  - Half with addr[0] = 1.
  - Word with addr[1:0] != 0.
  - addr + bytes > MEM_BYTES.
- Request capture: on acceptance, the owner, we, size, unsigned, addr and wdata are all registered. Later changes on the request ports have no effect.
- Arbitration:
  - Requests are considered only in IDLE; there is one outstanding transaction total.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port not granted last is granted (round-robin). The last-grant pointer resets to 1, so p0 wins the first tie.
  - The pointer updates only on acceptance.
- pN_req_ready = rst_n && state == IDLE && grant == N. This is combinational; the ungranted port sees 0.
- Load extension:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend from bit 7 or bit 15 unless unsigned = 1; word loads are passed through unchanged.
- mem_addr = {captured addr[31:2], 2'b00} in ACC/WR; 0 in IDLE, RESP and ERR.
- mem_wdata = 0 when mem_we = 0.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE and last-grant pointer = 1.
  - While rst_n is low: all req_ready and resp_valid are 0, mem_we is 0, and mem_addr, mem_wdata, resp_rdata, resp_err and busy are all 0.
  - Reset mid-transaction abandons the transaction. A WR aborted before its clock edge performs no write.
- Latency, measured from the acceptance edge T:
  - Load and SW: ACC in cycle T+1, resp_valid from cycle T+2.
  - SB/SH: ACC T+1, WR T+2 (write at the end of T+2), resp_valid from T+3.
  - Error: resp_valid from T+1; memory is never touched.
- Response holding:
  - resp_valid, rdata and err stay stable until resp_ready is sampled high.
  - If resp_ready is already high, the response lasts exactly one cycle.
- Next acceptance: no earlier than the cycle after the response handshake (IDLE). Back-to-back throughput is one load per 3 cycles.
- Read-modify-write atomicity: p1 cannot interleave between the read and write of a p0 sub-word store, and vice versa.

## Test plan
- Reset with both ports requesting -> no ready until rst_n is high; the first tie grants p0, the second grants p1; stalled-port request fields are ignored.
- p0 SW 0xDEADBEEF to 0x10, then LB unsigned at 0x11 -> resp 0x000000BE at T+2; LB signed at 0x13 -> 0xFFFFFFDE.
- SB 0x55 to 0x12 over word 0xDEADBEEF -> WR writes 0xDE55BEEF at T+2 with mem_we high for exactly 1 cycle; LH at 0x12 -> 0xFFFFDE55.
- LW at 0x6, SH at 0x3, size 11, and LW at 0x1000 -> resp_err = 1 with rdata 0 at T+1; mem_we never asserts.
- resp_ready held low for 5 cycles -> resp_valid and rdata are stable; the other port's pending request is not accepted until after the handshake.
- rst_n asserted during WR of an SB -> mem_we drops immediately, the memory word is unchanged, all outputs are 0, and the next request after release is accepted normally.
